// File: rtl/if_id_pkg.sv
// if_id_pkg: shared types and constants for the fetch/decode queue.
//   if_id_entry_t - one queued {instruction, PC+4} pair
//   NOP_INSTR     - word presented to decode when the queue is empty
package if_id_pkg;
    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc4;
    } if_id_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0;
endpackage

// File: rtl/if_id_queue.sv
// if_id_queue: elastic FIFO between instruction fetch and decode.
// Ports:
//   clk, reset           - clock; asynchronous active-low reset
//   in_valid/in_ready    - fetch handshake; in_instruction, in_pc4 are the offered entry
//   out_valid/out_ready  - decode handshake; out_instruction, out_pc4 are the head (NOP/0 when empty)
//   flush                - drop every entry, including a word pushed in the same cycle
//   count                - number of valid entries
module if_id_queue
    import if_id_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instruction,
    input  logic [31:0]                in_pc4,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instruction,
    output logic [31:0]                out_pc4,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    if_id_entry_t mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          push, pop;

    // Ready comes only from registered count, so a full queue refuses a push
    // even when decode pops in the same cycle.
    assign in_ready        = (count != FULL);
    assign out_valid       = (count != '0);
    assign push            = in_valid & in_ready;
    assign pop             = out_valid & out_ready;
    assign out_instruction = out_valid ? mem[rd_ptr].instruction : NOP_INSTR;
    assign out_pc4         = out_valid ? mem[rd_ptr].pc4 : 32'h0;

    // Storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= '{instruction: in_instruction, pc4: in_pc4};
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!push || count < FULL);
            assert (!pop || count != '0);
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed test of if_id_queue against a queue-based reference model.
module tb_if_id_queue;
    import if_id_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
    logic [31:0] in_instruction = '0, in_pc4 = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_instruction, out_pc4;
    logic [$clog2(DEPTH+1)-1:0] count;

    int n_chk = 0;
    int n_fail = 0;

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_pc4(in_pc4),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_pc4(out_pc4),
        .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of entries, emptied by flush or reset.
    if_id_entry_t q[$];
    bit m_push, m_pop;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
        end else begin
            m_push = in_valid && (q.size() < DEPTH);
            m_pop  = out_ready && (q.size() > 0);
            if (flush) begin
                q.delete();
            end else begin
                if (m_pop) void'(q.pop_front());
                if (m_push) q.push_back('{instruction: in_instruction, pc4: in_pc4});
            end
        end
    end

    always @(negedge clk) begin
        chk("m_count", 32'(count), 32'(q.size()));
        chk("m_in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
        chk("m_out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("m_out_instruction", out_instruction, q.size() != 0 ? q[0].instruction : 32'h0);
        chk("m_out_pc4", out_pc4, q.size() != 0 ? q[0].pc4 : 32'h0);
    end

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                         input logic r, input logic f);
        in_valid = v;
        in_instruction = i;
        in_pc4 = p;
        out_ready = r;
        flush = f;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1 reset = 1'b0;
        #11 reset = 1'b1;
        @(posedge clk);
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instruction, 32'h0);

        drive(1, 32'h00A1_0003, 32'h0000_0004, 0, 0);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_instr", out_instruction, 32'h00A1_0003);
        chk("single_pc4", out_pc4, 32'h0000_0004);
        chk("single_count", 32'(count), 32'd1);
        drive(0, 32'h0, 32'h0, 1, 0);
        chk("single_pop_count", 32'(count), 32'd0);
        chk("single_pop_instr", out_instruction, 32'h0);
        chk("single_pop_pc4", out_pc4, 32'h0);

        drive(1, 32'h1111_0001, 32'h8, 0, 0);
        chk("fill1_count", 32'(count), 32'd1);
        chk("fill1_ready", 32'(in_ready), 32'd1);
        drive(1, 32'h2222_0002, 32'hC, 0, 0);
        chk("fill2_count", 32'(count), 32'd2);
        chk("fill2_ready", 32'(in_ready), 32'd0);
        drive(1, 32'h3333_0003, 32'h10, 0, 0);
        chk("stall_count", 32'(count), 32'd2);
        chk("stall_head", out_instruction, 32'h1111_0001);
        drive(1, 32'h3333_0003, 32'h10, 1, 0);
        chk("full_pop_count", 32'(count), 32'd1);
        chk("full_pop_ready", 32'(in_ready), 32'd1);
        chk("full_pop_head", out_instruction, 32'h2222_0002);
        drive(1, 32'h3333_0003, 32'h10, 0, 0);
        chk("third_count", 32'(count), 32'd2);
        drive(0, 32'h0, 32'h0, 1, 0);
        chk("third_head", out_instruction, 32'h3333_0003);
        chk("third_pc4", out_pc4, 32'h10);
        drive(0, 32'h0, 32'h0, 1, 0);
        chk("drain_count", 32'(count), 32'd0);

        for (int i = 0; i < 16; i++) begin
            drive(1, 32'hA000_0000 + 32'(i), 32'(4 * (i + 1)), 1, 0);
            chk("stream_count", 32'(count), 32'd1);
            chk("stream_pc4", out_pc4, 32'(4 * (i + 1)));
        end

        drive(1, 32'hDEAD_BEEF, 32'h100, 1, 1);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        drive(1, 32'h5555_0005, 32'h104, 0, 0);
        chk("post_flush_instr", out_instruction, 32'h5555_0005);
        chk("post_flush_count", 32'(count), 32'd1);
        drive(0, 32'h0, 32'h0, 1, 0);

        for (int i = 0; i < 5; i++) begin
            drive(1, 32'hC000_0000 + 32'(i), 32'h200 + 32'(4 * i), 0, 0);
            chk("wrap_head", out_instruction, 32'hC000_0000 + 32'(i));
            drive(1, 32'hD000_0000 + 32'(i), 32'h300 + 32'(4 * i), 1, 0);
            chk("wrap_next", out_instruction, 32'hD000_0000 + 32'(i));
            drive(0, 32'h0, 32'h0, 1, 0);
        end

        drive(1, 32'hE000_0001, 32'h400, 0, 0);
        drive(1, 32'hE000_0002, 32'h404, 0, 0);
        chk("pre_rst_count", 32'(count), 32'd2);
        in_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_instr", out_instruction, 32'h0);
        chk("async_rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #2;
        chk("after_rst_count", 32'(count), 32'd0);
        drive(1, 32'hF000_000F, 32'h500, 0, 0);
        chk("after_rst_push", out_instruction, 32'hF000_000F);
        drive(0, 32'h0, 32'h0, 1, 0);
        drive(0, 32'h0, 32'h0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
